mem_wb_stage: RTL and testbench

Memory-access stage sitting directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM outputs and resolves branches (PCSrc). For loads and stores it runs a req/ack handshake with the data memory, with sub-doubleword lane steering, sign/zero extension, misalignment detection and a timeout. While an access is outstanding it stalls the upstream pipeline. Its results are registered into the MEM/WB pipeline register, which feeds writeback.

---
 rtl/mem_wb_stage_if.sv | 31 +++
 rtl/mem_wb_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus used by the memory-access stage.
// The stage is the master; the data memory (or its model) is the slave.
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage: branch resolve, dmem req/ack with lane steering,
// load extension, misalign detect, timeout, and the MEM/WB register.
module mem_wb_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_in,
    input  logic        Branch_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [63:0] Adder_B_in,
    input  logic [63:0] Result_in,
    input  logic        ZERO_in,
    input  logic [63:0] data_in,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic        stall,
    mem_wb_stage_if.master dmem,
    output logic [4:0]  rd_out,
    output logic        RegWrite_out,
    output logic        MemtoReg_out,
    output logic [63:0] ReadData_out,
    output logic [63:0] Result_out,
    output logic        misalign,
    output logic        mem_err
);
    typedef enum logic { IDLE, ACCESS } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt;
    logic [1:0]  size;
    logic [2:0]  a;
    logic        memop, mis;
    logic        start, finish, tmo, pass, bubble, mis_p;
    logic [7:0]  wstrb_n;
    logic [63:0] wdata_n, lane, ld_ext;

    assign PCSrc          = Branch_in & ZERO_in;
    assign branch_target  = Adder_B_in;
    assign size           = funct3_in[1:0];
    assign a              = Result_in[2:0];
    assign memop          = MemRead_in | MemWrite_in;
    assign dmem.dmem_addr = {Result_in[63:3], 3'b000};
    assign lane           = dmem.dmem_rdata >> {a, 3'b000};

    assign mis = (size == 2'b01 && a[0]) ||
                 (size == 2'b10 && a[1:0] != 2'b00) ||
                 (size == 2'b11 && a != 3'b000);

    // Hold upstream while an aligned access is being launched or awaits ack.
    assign stall = (state == IDLE && memop && !mis) ||
                   (state == ACCESS && !dmem.dmem_ack);

    // Store byte enables and replicated write data for the access size.
    always_comb begin
        wstrb_n = 8'h00;
        wdata_n = data_in;
        unique case (size)
            2'b00: begin
                wstrb_n = 8'h01 << a;
                wdata_n = {8{data_in[7:0]}};
            end
            2'b01: begin
                wstrb_n = 8'h03 << a;
                wdata_n = {4{data_in[15:0]}};
            end
            2'b10: begin
                wstrb_n = 8'h0F << a;
                wdata_n = {2{data_in[31:0]}};
            end
            default: begin
                wstrb_n = 8'hFF;
                wdata_n = data_in;
            end
        endcase
    end

    // Load lane truncation followed by sign or zero extension.
    always_comb begin
        ld_ext = lane;
        unique case (size)
            2'b00: ld_ext = funct3_in[2] ? {56'b0, lane[7:0]}
                                         : {{56{lane[7]}}, lane[7:0]};
            2'b01: ld_ext = funct3_in[2] ? {48'b0, lane[15:0]}
                                         : {{48{lane[15]}}, lane[15:0]};
            2'b10: ld_ext = funct3_in[2] ? {32'b0, lane[31:0]}
                                         : {{32{lane[31]}}, lane[31:0]};
            default: ld_ext = lane;
        endcase
    end

    // Next state and per-cycle actions; ack in IDLE is never looked at.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        finish  = 1'b0;
        tmo     = 1'b0;
        pass    = 1'b0;
        bubble  = 1'b0;
        mis_p   = 1'b0;
        unique case (state)
            IDLE: begin
                if (memop && mis) begin
                    mis_p  = 1'b1;
                    bubble = 1'b1;
                end else if (memop) begin
                    start   = 1'b1;
                    bubble  = 1'b1;
                    state_n = ACCESS;
                end else begin
                    pass = 1'b1;
                end
            end
            ACCESS: begin
                if (dmem.dmem_ack) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end else if (cnt == 8'(MAX_WAIT - 1)) begin
                    tmo     = 1'b1;
                    bubble  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state, wait counter and the registered memory request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_wstrb <= 8'h00;
            dmem.dmem_wdata <= 64'd0;
        end else begin
            state <= state_n;
            if (start) begin
                cnt             <= 8'd0;
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= MemWrite_in;
                dmem.dmem_wstrb <= MemWrite_in ? wstrb_n : 8'h00;
                dmem.dmem_wdata <= wdata_n;
            end else if (finish || tmo) begin
                dmem.dmem_req   <= 1'b0;
                dmem.dmem_we    <= 1'b0;
                dmem.dmem_wstrb <= 8'h00;
            end else if (state == ACCESS) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // MEM/WB pipeline register plus misalign pulse and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_out       <= 5'd0;
            RegWrite_out <= 1'b0;
            MemtoReg_out <= 1'b0;
            ReadData_out <= 64'd0;
            Result_out   <= 64'd0;
            misalign     <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            misalign <= mis_p;
            mem_err  <= mem_err | tmo;
            if (pass || finish) begin
                rd_out       <= rd_in;
                RegWrite_out <= RegWrite_in;
                MemtoReg_out <= MemtoReg_in;
                Result_out   <= Result_in;
                ReadData_out <= (finish && !MemWrite_in) ? ld_ext : 64'd0;
            end else if (bubble) begin
                RegWrite_out <= 1'b0;
                MemtoReg_out <= 1'b0;
                ReadData_out <= 64'd0;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
// Inputs change and outputs are sampled after the falling edge.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_in;
    logic        Branch_in, MemWrite_in, MemRead_in;
    logic        MemtoReg_in, RegWrite_in, ZERO_in;
    logic [2:0]  funct3_in;
    logic [63:0] Adder_B_in, Result_in, data_in;
    logic        PCSrc, stall;
    logic [63:0] branch_target;
    logic [4:0]  rd_out;
    logic        RegWrite_out, MemtoReg_out, misalign, mem_err;
    logic [63:0] ReadData_out, Result_out;
    int          total = 0;
    int          bad = 0;
    int          n;

    mem_wb_stage_if dmem ();

    mem_wb_stage #(.MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_in        (rd_in),
        .Branch_in    (Branch_in),
        .MemWrite_in  (MemWrite_in),
        .MemRead_in   (MemRead_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWrite_in  (RegWrite_in),
        .funct3_in    (funct3_in),
        .Adder_B_in   (Adder_B_in),
        .Result_in    (Result_in),
        .ZERO_in      (ZERO_in),
        .data_in      (data_in),
        .PCSrc        (PCSrc),
        .branch_target(branch_target),
        .stall        (stall),
        .dmem         (dmem.master),
        .rd_out       (rd_out),
        .RegWrite_out (RegWrite_out),
        .MemtoReg_out (MemtoReg_out),
        .ReadData_out (ReadData_out),
        .Result_out   (Result_out),
        .misalign     (misalign),
        .mem_err      (mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nop();
        rd_in = 5'd0; Branch_in = 1'b0; MemWrite_in = 1'b0;
        MemRead_in = 1'b0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
        ZERO_in = 1'b0; funct3_in = 3'b000; Adder_B_in = 64'd0;
        Result_in = 64'd0; data_in = 64'd0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        nop();
        dmem.dmem_ack = 1'b0;
        dmem.dmem_rdata = 64'd0;
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_req", 64'(dmem.dmem_req), 64'd0);
        chk("rst_wstrb", 64'(dmem.dmem_wstrb), 64'd0);
        chk("rst_wdata", dmem.dmem_wdata, 64'd0);
        chk("rst_regwr", 64'(RegWrite_out), 64'd0);
        chk("rst_result", Result_out, 64'd0);
        chk("rst_err", 64'(mem_err), 64'd0);
        reset = 1'b1;
        tick();

        // ALU pass-through
        RegWrite_in = 1'b1; rd_in = 5'd5; Result_in = 64'h1234;
        #1;
        chk("pass_stall", 64'(stall), 64'd0);
        tick();
        chk("pass_rd", 64'(rd_out), 64'd5);
        chk("pass_regwr", 64'(RegWrite_out), 64'd1);
        chk("pass_result", Result_out, 64'h1234);
        chk("pass_rdata", ReadData_out, 64'd0);

        // LB sign-extend, ack on second ACCESS cycle
        nop();
        MemRead_in = 1'b1; RegWrite_in = 1'b1; MemtoReg_in = 1'b1;
        rd_in = 5'd7; funct3_in = 3'b000; Result_in = 64'h1003;
        dmem.dmem_rdata = 64'h0000_0000_8000_0000;
        #1;
        chk("lb_addr", dmem.dmem_addr, 64'h1000);
        n = 0;
        if (stall) n++;
        tick();
        chk("lb_req", 64'(dmem.dmem_req), 64'd1);
        chk("lb_we", 64'(dmem.dmem_we), 64'd0);
        chk("lb_bubble", 64'(RegWrite_out), 64'd0);
        if (stall) n++;
        tick();
        if (stall) n++;
        dmem.dmem_ack = 1'b1;
        #1;
        chk("lb_ack_stall", 64'(stall), 64'd0);
        chk("lb_stall_cyc", 64'(n), 64'd3);
        tick();
        dmem.dmem_ack = 1'b0;
        nop();
        chk("lb_rdata", ReadData_out, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_rd", 64'(rd_out), 64'd7);
        chk("lb_m2r", 64'(MemtoReg_out), 64'd1);
        chk("lb_req_off", 64'(dmem.dmem_req), 64'd0);

        // LBU zero-extend, same lane, ack in first ACCESS cycle
        MemRead_in = 1'b1; RegWrite_in = 1'b1; rd_in = 5'd8;
        funct3_in = 3'b100; Result_in = 64'h1003;
        tick();
        dmem.dmem_ack = 1'b1;
        tick();
        dmem.dmem_ack = 1'b0;
        nop();
        chk("lbu_rdata", ReadData_out, 64'h80);

        // SH store at 0x2006
        MemWrite_in = 1'b1; funct3_in = 3'b001;
        Result_in = 64'h2006; data_in = 64'hABCD;
        tick();
        chk("sh_wstrb", 64'(dmem.dmem_wstrb), 64'hC0);
        chk("sh_wdata", dmem.dmem_wdata, 64'hABCD_ABCD_ABCD_ABCD);
        chk("sh_we", 64'(dmem.dmem_we), 64'd1);
        chk("sh_addr", dmem.dmem_addr, 64'h2000);
        dmem.dmem_ack = 1'b1;
        tick();
        dmem.dmem_ack = 1'b0;
        nop();
        chk("sh_regwr", 64'(RegWrite_out), 64'd0);
        chk("sh_rdata", ReadData_out, 64'd0);
        chk("sh_req_off", 64'(dmem.dmem_req), 64'd0);

        // Misaligned LW
        MemRead_in = 1'b1; RegWrite_in = 1'b1; rd_in = 5'd9;
        funct3_in = 3'b010; Result_in = 64'h1002;
        #1;
        chk("mis_stall", 64'(stall), 64'd0);
        tick();
        nop();
        chk("mis_pulse", 64'(misalign), 64'd1);
        chk("mis_req", 64'(dmem.dmem_req), 64'd0);
        chk("mis_regwr", 64'(RegWrite_out), 64'd0);
        tick();
        chk("mis_pulse_end", 64'(misalign), 64'd0);

        // Branch resolve
        Branch_in = 1'b1; ZERO_in = 1'b1; Adder_B_in = 64'h4444;
        #1;
        chk("pcsrc_taken", 64'(PCSrc), 64'd1);
        chk("br_target", branch_target, 64'h4444);
        ZERO_in = 1'b0;
        #1;
        chk("pcsrc_nt", 64'(PCSrc), 64'd0);
        nop();

        // Timeout with MAX_WAIT=4
        MemRead_in = 1'b1; RegWrite_in = 1'b1; rd_in = 5'd3;
        funct3_in = 3'b011; Result_in = 64'h3000;
        tick();
        n = 0;
        while (dmem.dmem_req && n < 20) begin
            n++;
            tick();
        end
        nop();
        chk("tmo_cycles", 64'(n), 64'd4);
        chk("tmo_err", 64'(mem_err), 64'd1);
        chk("tmo_regwr", 64'(RegWrite_out), 64'd0);
        dmem.dmem_ack = 1'b1;
        dmem.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        dmem.dmem_ack = 1'b0;
        chk("late_ack_rdata", ReadData_out, 64'd0);
        chk("late_ack_req", 64'(dmem.dmem_req), 64'd0);
        tick();
        chk("err_sticky", 64'(mem_err), 64'd1);

        // Reset asserted mid-ACCESS
        MemRead_in = 1'b1; funct3_in = 3'b010; Result_in = 64'h1000;
        tick();
        chk("mid_req_on", 64'(dmem.dmem_req), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 64'(dmem.dmem_req), 64'd0);
        chk("mid_rst_err", 64'(mem_err), 64'd0);
        nop();
        tick();
        reset = 1'b1;
        #1;
        chk("post_rst_stall", 64'(stall), 64'd0);
        tick();
        chk("post_rst_req", 64'(dmem.dmem_req), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
